word_scatter8: RTL and testbench
================================

// Module: word_scatter8
// PURPOSE
//  Serial-to-parallel scatter unit: accepts a stream of WIDTH-bit words over a
//  valid/ready handshake and deposits them in order into eight lane registers a..h.
//  Presents the completed 8-lane frame with out_valid/out_ready and a 1-bit
//  all-ones flag q (&{a..h}). Opposite end of the 8-port reduction datapath: feeds
//  the eight lane operands that the reducer consumes.
// PARAMETERS
//  WIDTH     8   bits per word and per lane register
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      asynchronous, active-high; clears all state
//  clear      in   1      synchronous abort: discard partial/held frame
//  in_data    in   WIDTH  incoming word
//  in_valid   in   1      in_data valid
//  in_ready   out  1      block can accept a word this cycle
//  a..h       out  WIDTH  lane registers, lane 0 = a ... lane 7 = h
//  out_valid  out  1      all 8 lanes hold a complete frame
//  out_ready  in   1      consumer takes the frame
//  q          out  1      &{a,b,c,d,e,f,g,h} while out_valid, else 0
//  fill_cnt   out  4      lanes written in the current frame, 0..8
// BEHAVIOUR
//  Reset (async, any time): state=FILL, idx=0, a..h=0, out_valid=0, fill_cnt=0, q=0.
//   After reset deasserts, in_ready=1.
//  States: FILL (collecting), HOLD (frame presented).
//  in_ready = (state==FILL) && !clear. It is combinational from state and clear.
//  FILL: on in_valid&&in_ready, lane[idx]<=in_data, idx<=idx+1, fill_cnt+=1.
//   An accept at idx==7 moves to HOLD. out_valid=1 from the next cycle. No skipped lanes.
//  HOLD: in_ready=0. a..h are frozen. out_valid=1. fill_cnt=8.
//   out_ready=1 -> FILL, idx=0, fill_cnt=0, out_valid=0 next cycle.
//   Lanes keep their old values until overwritten.
//  Throughput: 8 accepts + 1 handoff cycle min. out_ready and in_valid in the same
//   HOLD cycle: no word accepted (in_ready=0); first word of next frame accepted
//   in the following cycle (1-cycle bubble, fixed).
//  in_valid=0 in FILL: no state change. Partial frames wait indefinitely.
//  clear=1 (any state, priority over handshakes): next cycle FILL, idx=0, fill_cnt=0,
//   out_valid=0. Lane contents are unchanged. The word present during clear is not accepted.
//  reset mid-frame or during HOLD: full reset values. The partial frame is lost.
//  idx is 3 bits and wraps only via the FILL->HOLD->FILL path. It never overruns.
//  q: combinational reduction AND over 8*WIDTH bits, ANDed with out_valid.
//  Upstream may hold in_valid while in_ready=0. Data must then be stable. Block never drops an accepted word.
// TESTING (WIDTH=7)
//  1 reset then in 0x7F x8 back-to-back -> in_ready 1 for 8 cycles, out_valid=1 on
//    cycle 9, a..h=0x7F, q=1, fill_cnt=8.
//  2 words 0x01..0x08 with out_ready=1 held -> a=0x01..h=0x08, q=0, out_valid pulses
//    1 cycle, next frame's first word accepted 1 cycle after handoff.
//  3 frame of 0x7F except f=0x7E -> out_valid=1, q=0. Then frame all 0x7F -> q=1.
//  4 HOLD with out_ready=0 for 5 cycles, in_valid=1 -> in_ready=0, a..h stable,
//    no word consumed. out_ready=1 -> FILL, fill_cnt=0.
//  5 write 3 words, clear=1 with in_valid=1 -> that word not taken, fill_cnt=0,
//    next word lands in a. Repeat clear in HOLD -> out_valid drops next cycle.
//  6 assert reset asynchronously mid-frame (between edges) and during HOLD -> outputs
//    zero immediately, out_valid=0, q=0, in_ready=1 after release.

Source files
------------

// File: rtl/word_scatter8_if.sv
// Handshake bundle for the 8-lane scatter unit: input word stream, frame output, control.
// No latency of its own; pure wiring between producer/consumer and the block.
// in_valid/in_ready on the word side; out_valid/out_ready on the frame side.
interface word_scatter8_if #(
    parameter int WIDTH = 8
);
    logic             clear;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] h;
    logic             out_valid;
    logic             out_ready;
    logic             q;
    logic [3:0]       fill_cnt;

    // Producer/consumer side: drives words, clear and frame acceptance.
    modport master (
        output clear, in_data, in_valid, out_ready,
        input  in_ready, a, b, c, d, e, f, g, h, out_valid, q, fill_cnt
    );

    // Block side.
    modport slave (
        input  clear, in_data, in_valid, out_ready,
        output in_ready, a, b, c, d, e, f, g, h, out_valid, q, fill_cnt
    );
endinterface

// File: rtl/word_scatter8.sv
// Serial-to-parallel scatter: deposits 8 consecutive words into lanes a..h, presents the frame.
// Frame valid the cycle after the 8th accept; handoff costs one bubble cycle before the next word.
// in_ready low while a frame is held or clear is asserted; held frame waits for out_ready.
module word_scatter8 #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    word_scatter8_if.slave bus
);
    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state;
    logic [2:0]       idx;
    logic [WIDTH-1:0] lane [8];
    logic [3:0]       fill_cnt_r;
    logic             out_valid_r;

    // Accept only while collecting; clear blocks the word presented alongside it.
    assign bus.in_ready  = (state == FILL) && !bus.clear;

    assign bus.a         = lane[0];
    assign bus.b         = lane[1];
    assign bus.c         = lane[2];
    assign bus.d         = lane[3];
    assign bus.e         = lane[4];
    assign bus.f         = lane[5];
    assign bus.g         = lane[6];
    assign bus.h         = lane[7];
    assign bus.out_valid = out_valid_r;
    assign bus.fill_cnt  = fill_cnt_r;

    // All-ones flag is only meaningful for a presented frame; stale lanes never raise it.
    assign bus.q = (&{lane[7], lane[6], lane[5], lane[4],
                      lane[3], lane[2], lane[1], lane[0]}) & out_valid_r;

    // Fill/hold sequencer; clear outranks both handshakes but leaves lane contents alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FILL;
            idx         <= 3'd0;
            fill_cnt_r  <= 4'd0;
            out_valid_r <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                lane[i] <= '0;
            end
        end else if (bus.clear) begin
            state       <= FILL;
            idx         <= 3'd0;
            fill_cnt_r  <= 4'd0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (bus.in_valid) begin
                        lane[idx]  <= bus.in_data;
                        idx        <= idx + 3'd1;
                        fill_cnt_r <= fill_cnt_r + 4'd1;
                        if (idx == 3'd7) begin
                            state       <= HOLD;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state       <= FILL;
                        idx         <= 3'd0;
                        fill_cnt_r  <= 4'd0;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_word_scatter8.sv
// Randomized and directed bench for word_scatter8 with a frame-level reference model.
// Completed frames are queued by the driver and retired by an independent monitor.
// Per-cycle checks cover in_ready, out_valid, fill_cnt, lane contents and q.
module tb_word_scatter8;
    localparam int W = 7;

    logic clk = 1'b0;
    logic reset;

    word_scatter8_if #(.WIDTH(W)) bus ();

    word_scatter8 #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: lane contents, words taken in the current frame, frame-held flag.
    logic [W-1:0]   ml [8];
    int             cnt;
    bit             held;
    logic [8*W-1:0] sb [$];

    function automatic logic [8*W-1:0] model_frame();
        logic [8*W-1:0] fr;
        for (int i = 0; i < 8; i++) fr[i*W +: W] = ml[i];
        return fr;
    endfunction

    function automatic logic [8*W-1:0] dut_frame();
        return {bus.h, bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a};
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive, check against model mid-cycle, then advance model.
    task automatic cycle(input bit vld, input logic [W-1:0] dat, input bit ordy, input bit clr);
        logic [8*W-1:0] mf;
        bus.in_valid  = vld;
        bus.in_data   = dat;
        bus.out_ready = ordy;
        bus.clear     = clr;
        @(negedge clk);
        mf = model_frame();
        chk("in_ready",  longint'(bus.in_ready),  longint'(!held && !clr));
        chk("out_valid", longint'(bus.out_valid), longint'(held));
        chk("fill_cnt",  longint'(bus.fill_cnt),  longint'(held ? 8 : cnt));
        chk("lanes",     longint'(dut_frame()),   longint'(mf));
        chk("q",         longint'(bus.q),         longint'(held && (&mf)));
        @(posedge clk);
        if (clr) begin
            cnt  = 0;
            held = 0;
        end else if (!held) begin
            if (vld) begin
                ml[cnt] = dat;
                cnt++;
                if (cnt == 8) begin
                    held = 1;
                    sb.push_back(model_frame());
                end
            end
        end else if (ordy) begin
            held = 0;
            cnt  = 0;
        end
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) ml[i] = '0;
        cnt  = 0;
        held = 0;
        sb.delete();
    endtask

    // Reset asserted between clock edges; outputs must clear without waiting for a clock.
    task automatic async_reset();
        bus.in_valid  = 1'b0;
        bus.clear     = 1'b0;
        bus.out_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("rst_lanes",     longint'(dut_frame()),   0);
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_q",         longint'(bus.q),         0);
        chk("rst_fill_cnt",  longint'(bus.fill_cnt),  0);
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", longint'(bus.in_ready), 1);
    endtask

    // Monitor: retire a frame whenever the DUT presents one and it leaves (taken or cleared).
    always @(negedge clk) begin
        logic [8*W-1:0] exp_fr;
        if (!reset && bus.out_valid && (bus.out_ready || bus.clear)) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", longint'(sb.size()), 1);
            end else begin
                exp_fr = sb.pop_front();
                chk("frame",   longint'(dut_frame()), longint'(exp_fr));
                chk("frame_q", longint'(bus.q),       longint'(&exp_fr));
            end
        end
    end

    initial begin
        bit             pend;
        logic [W-1:0]   pd;
        bit             vld, ordy, clr;
        logic [W-1:0]   dat;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.clear     = 1'b0;
        model_reset();
        #12;
        chk("init_lanes",     longint'(dut_frame()),   0);
        chk("init_out_valid", longint'(bus.out_valid), 0);
        chk("init_fill_cnt",  longint'(bus.fill_cnt),  0);
        chk("init_q",         longint'(bus.q),         0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // All-ones frame back to back, then held, then handed off.
        for (int i = 0; i < 8; i++) cycle(1, 7'h7F, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);

        // Ascending words with out_ready held: one-cycle bubble before next frame.
        for (int i = 1; i <= 8; i++) cycle(1, W'(i), 1, 0);
        cycle(1, 7'h33, 1, 0);
        cycle(1, 7'h33, 1, 0);
        for (int i = 0; i < 7; i++) cycle(1, 7'h7F, 1, 0);
        cycle(0, 0, 1, 0);

        // One lane short of all-ones, then a true all-ones frame.
        for (int i = 0; i < 8; i++) cycle(1, (i == 5) ? 7'h7E : 7'h7F, 0, 0);
        cycle(0, 0, 1, 0);
        for (int i = 0; i < 8; i++) cycle(1, 7'h7F, 0, 0);

        // Frame held against a persistent upstream word, then released.
        for (int i = 0; i < 5; i++) cycle(1, 7'h2A, 0, 0);
        cycle(1, 7'h2A, 1, 0);
        cycle(1, 7'h2A, 0, 0);
        for (int i = 0; i < 7; i++) cycle(1, W'(i + 16), 0, 0);
        cycle(0, 0, 1, 0);

        // Clear mid-frame with a word present, then clear while holding.
        for (int i = 0; i < 3; i++) cycle(1, W'(i + 40), 0, 0);
        cycle(1, 7'h55, 0, 1);
        cycle(1, 7'h11, 0, 0);
        for (int i = 0; i < 7; i++) cycle(1, W'(i + 60), 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);

        // Asynchronous reset mid-frame and during hold.
        for (int i = 0; i < 4; i++) cycle(1, 7'h7F, 0, 0);
        async_reset();
        for (int i = 0; i < 8; i++) cycle(1, 7'h7F, 0, 0);
        cycle(0, 0, 0, 0);
        async_reset();

        // Random traffic; a refused word is held stable until taken.
        pend = 0;
        pd   = '0;
        for (int n = 0; n < 600; n++) begin
            vld  = pend ? 1'b1 : ($urandom_range(0, 3) != 0);
            dat  = pend ? pd : (($urandom_range(0, 1) == 1) ? 7'h7F : W'($urandom_range(0, 127)));
            ordy = ($urandom_range(0, 2) != 0);
            clr  = ($urandom_range(0, 39) == 0);
            pend = vld && (held || clr);
            pd   = dat;
            cycle(vld, dat, ordy, clr);
        end

        // Drain any held frame so every queued frame is retired.
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        chk("sb_empty", longint'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
